uart_rx_link_ctrl: RTL

// - Sequencer/configurator in front of the UART RX core (sampler, deserializer, edge/bit counter, FSM, checkers).
// - Accepts runtime config via valid/ready and applies it only between frames:

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_idle_detect.sv | 58 +++++
 rtl/uart_rx_link_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX link controller and its idle detector.
//   link_state_t  : sequencer state (DISABLED, APPLY, WAIT_IDLE, ACTIVE)
//   APPLY_CYCLES  : number of cycles spent in APPLY
//   PRESCALE_W    : width of the prescale (oversample clocks per bit) field
//   DATA_W        : received byte width
package uart_rx_pkg;

   typedef enum logic [1:0] {
      DISABLED  = 2'd0,
      APPLY     = 2'd1,
      WAIT_IDLE = 2'd2,
      ACTIVE    = 2'd3
   } link_state_t;

   localparam int APPLY_CYCLES = 2;
   localparam int APPLY_CNT_W  = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;
   localparam int PRESCALE_W   = 4;
   localparam int DATA_W       = 8;

endpackage

// File: rtl/uart_rx_idle_detect.sv
// Line idle detector.
// Counts oversample clocks while the RX line is high; every prescale clocks is
// one high bit-time. After IDLE_BITS consecutive high bit-times the line is
// reported idle. Any low sample (start bit) restarts the qualification.
//   CLK, RST     : clock, synchronous active-high reset
//   clear        : restart qualification (used when a new config is applied)
//   Serial_Data  : raw RX line
//   prescale     : oversample clocks per bit currently applied
//   line_idle    : IDLE_BITS high bit-times seen since the last low/clear
module uart_rx_idle_detect
   import uart_rx_pkg::*;
#(
   parameter int IDLE_BITS = 11
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  clear,
   input  logic                  Serial_Data,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  line_idle
);

   localparam logic [3:0] IDLE_MAX = 4'(IDLE_BITS);

   logic [PRESCALE_W-1:0] bit_cnt_reg, bit_cnt_next;
   logic [3:0]            idle_cnt_reg, idle_cnt_next;

   always_comb begin
      bit_cnt_next  = bit_cnt_reg;
      idle_cnt_next = idle_cnt_reg;
      if (clear || !Serial_Data) begin
         bit_cnt_next  = '0;
         idle_cnt_next = '0;
      end else if (bit_cnt_reg >= prescale - PRESCALE_W'(1)) begin
         // '>=' keeps the counter bounded if prescale ever shrinks mid-count
         bit_cnt_next = '0;
         if (idle_cnt_reg != IDLE_MAX) begin
            idle_cnt_next = idle_cnt_reg + 4'd1;
         end
      end else begin
         bit_cnt_next = bit_cnt_reg + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt_reg  <= '0;
         idle_cnt_reg <= '0;
      end else begin
         bit_cnt_reg  <= bit_cnt_next;
         idle_cnt_reg <= idle_cnt_next;
      end
   end

   assign line_idle = (idle_cnt_reg == IDLE_MAX);

endmodule

// File: rtl/uart_rx_link_ctrl.sv
// UART RX link controller.
// Sits in front of the RX core: accepts runtime configuration over a
// valid/ready handshake and applies it only between frames (core held in
// reset, shadow registers loaded, line verified idle, core released). Received
// bytes go into a one-entry holding register for a valid/ready consumer, with
// sticky overrun flagging and saturating frame/drop counters.
//   Cfg_*                : config request/accept/reject
//   Serial_Data          : raw RX line (idle monitoring)
//   RX_Data_Valid/Data   : byte-done pulse and byte from the core
//   RX_Core_RST, RX_*    : reset and applied settings to the core
//   Out_*                : holding register towards the consumer
//   Overrun, Stat_Clr    : sticky drop flag and statistics clear
//   Frame_Count/Drop_Count : accepted / dropped bytes
module uart_rx_link_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DEF_PRESCALE = 8,
   parameter int IDLE_BITS    = 11,
   parameter int CNT_W        = 16
)
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Cfg_Valid,
   output logic                  Cfg_Ready,
   input  logic                  Cfg_Rx_Enable,
   input  logic [PRESCALE_W-1:0] Cfg_Prescale,
   input  logic                  Cfg_Parity_Enable,
   input  logic                  Cfg_Parity_Type,
   output logic                  Cfg_Error,
   input  logic                  Serial_Data,
   input  logic                  RX_Data_Valid,
   input  logic [DATA_W-1:0]     RX_Parallel_Data,
   output logic                  RX_Core_RST,
   output logic [PRESCALE_W-1:0] RX_Prescale,
   output logic                  RX_Parity_Enable,
   output logic                  RX_Parity_Type,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic [DATA_W-1:0]     Out_Data,
   output logic                  Overrun,
   input  logic                  Stat_Clr,
   output logic [CNT_W-1:0]      Frame_Count,
   output logic [CNT_W-1:0]      Drop_Count
);

   localparam logic [APPLY_CNT_W-1:0] APPLY_LAST = APPLY_CNT_W'(APPLY_CYCLES - 1);
   localparam logic [CNT_W-1:0]       CNT_MAX    = '1;

   link_state_t              state_reg, state_next;
   logic [APPLY_CNT_W-1:0]   apply_cnt_reg, apply_cnt_next;
   logic [PRESCALE_W-1:0]    prescale_reg;
   logic                     par_en_reg, par_type_reg, rx_en_reg;
   logic                     cfg_error_reg;
   logic                     out_valid_reg;
   logic [DATA_W-1:0]        out_data_reg;
   logic                     overrun_reg;
   logic [CNT_W-1:0]         frame_cnt_reg, drop_cnt_reg;

   logic cfg_ready, cfg_fire, cfg_ok, cfg_bad;
   logic line_idle;
   logic capture, load, drop;

   uart_rx_idle_detect #(.IDLE_BITS(IDLE_BITS)) u_idle (
      .CLK         (CLK),
      .RST         (RST),
      .clear       (cfg_ok),
      .Serial_Data (Serial_Data),
      .prescale    (prescale_reg),
      .line_idle   (line_idle)
   );

   // Sequencer: next state and config acceptance
   always_comb begin
      state_next     = state_reg;
      apply_cnt_next = apply_cnt_reg;
      cfg_ready      = 1'b0;
      case (state_reg)
         DISABLED:  cfg_ready = 1'b1;
         APPLY: begin
            if (apply_cnt_reg == APPLY_LAST) begin
               state_next = rx_en_reg ? WAIT_IDLE : DISABLED;
            end else begin
               apply_cnt_next = apply_cnt_reg + APPLY_CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            if (line_idle) state_next = ACTIVE;
         end
         // Ready only while the line is idle, so a frame in flight can never
         // be cut by a reconfiguration.
         ACTIVE:    cfg_ready = line_idle;
         default:   state_next = DISABLED;
      endcase
      cfg_fire = Cfg_Valid && cfg_ready;
      cfg_ok   = cfg_fire && (Cfg_Prescale != '0);
      cfg_bad  = cfg_fire && (Cfg_Prescale == '0);
      if (cfg_ok) begin
         state_next     = APPLY;
         apply_cnt_next = '0;
      end
   end

   // Holding register control
   always_comb begin
      capture = (state_reg == ACTIVE) && RX_Data_Valid;
      load    = capture && (!out_valid_reg || Out_Ready);
      drop    = capture && out_valid_reg && !Out_Ready;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg     <= DISABLED;
         apply_cnt_reg <= '0;
         prescale_reg  <= PRESCALE_W'(DEF_PRESCALE);
         par_en_reg    <= 1'b0;
         par_type_reg  <= 1'b0;
         rx_en_reg     <= 1'b0;
         cfg_error_reg <= 1'b0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         overrun_reg   <= 1'b0;
         frame_cnt_reg <= '0;
         drop_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         apply_cnt_reg <= apply_cnt_next;
         cfg_error_reg <= cfg_bad;

         if (cfg_ok) begin
            prescale_reg <= Cfg_Prescale;
            par_en_reg   <= Cfg_Parity_Enable;
            par_type_reg <= Cfg_Parity_Type;
            rx_en_reg    <= Cfg_Rx_Enable;
         end

         if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= RX_Parallel_Data;
         end else if (out_valid_reg && Out_Ready) begin
            out_valid_reg <= 1'b0;
         end

         // A clear coinciding with a capture or drop wins outright
         if (Stat_Clr) begin
            overrun_reg   <= 1'b0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
         end else begin
            if (drop) begin
               overrun_reg <= 1'b1;
               if (drop_cnt_reg != CNT_MAX) drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            end
            if (load && (frame_cnt_reg != CNT_MAX)) begin
               frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
         end
      end
   end

   assign Cfg_Ready        = cfg_ready;
   assign Cfg_Error        = cfg_error_reg;
   assign RX_Core_RST      = (state_reg != ACTIVE);
   assign RX_Prescale      = prescale_reg;
   assign RX_Parity_Enable = par_en_reg;
   assign RX_Parity_Type   = par_type_reg;
   assign Out_Valid        = out_valid_reg;
   assign Out_Data         = out_data_reg;
   assign Overrun          = overrun_reg;
   assign Frame_Count      = frame_cnt_reg;
   assign Drop_Count       = drop_cnt_reg;

endmodule
